fft_mag_stream: RTL and testbench

- Producer end of the `mag`/`mag_valid` stream that feeds the peak finder in the pitch-detect chain.
- Accepts complex FFT bins (`re`, `im`) from the FFT core, one bin per accepted beat, possibly with gaps.
- Computes squared magnitude `re²+im²` for each bin and buffers whole frames in a ping-pong RAM.
- Replays each frame as one gap-free burst of exactly NSamples beats with `mag_valid` held high, which is what the peak finder requires.

---
 rtl/fft_mag_stream.sv | 174 +++++++++++++++++
 tb/tb_fft_mag_stream.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_mag_stream.sv
// Squared-magnitude stage for FFT bins with a ping-pong frame buffer that replays each
// frame as one gap-free burst. Optional macro FFT_MAG_BACKPRESSURE_EN stalls input instead of dropping.
module fft_mag_stream #(
  parameter int NSamples = 256,
  parameter int DW       = 16,
  parameter int W        = 2*DW+1,
  parameter int NBits    = $clog2(NSamples)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [DW-1:0] re,
  input  logic signed [DW-1:0] im,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [W-1:0]         mag,
  output logic                 mag_valid,
  output logic                 frame_err
);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_BURST, S_GAP} rd_state_e;

  localparam logic [NBits-1:0] LastIdx = NBits'(NSamples - 1);

  rd_state_e        state, state_nxt;
  logic [1:0]       full, full_nxt;
  logic             wr_bank, rd_bank;
  logic [NBits-1:0] wr_cnt, rd_cnt, rd_addr;
  logic             rd_en, burst_done, full_set;
  logic             wr_bank_free, start_blocked;
  logic             accept, take, at_end, commit, misalign, overflow;

  logic             s1_valid, s1_commit, s1_bank;
  logic [NBits-1:0] s1_addr;
  logic [2*DW-1:0]  s1_rr, s1_ii;
  logic             s2_valid, s2_commit, s2_bank;
  logic [NBits-1:0] s2_addr;
  logic [W-1:0]     s2_sum;
  logic signed [2*DW-1:0] re_x, im_x;

  logic [W-1:0]     mem [2*NSamples];

  // ---------------------------------------------------------------- write side
  // A bank already in BURST may take the next frame: its reader is past address 0 and
  // advances every cycle, so the writer can never overtake it.
  assign wr_bank_free  = !full[wr_bank] || (rd_bank == wr_bank && state == S_BURST);
  assign start_blocked = (wr_cnt == '0) && !wr_bank_free;
  assign accept        = in_valid && in_ready;

`ifdef FFT_MAG_BACKPRESSURE_EN
  assign in_ready = !start_blocked;
  assign take     = accept;
  assign overflow = 1'b0;
`else
  logic dropping;

  assign in_ready = 1'b1;
  assign take     = accept && !dropping && !start_blocked;
  assign overflow = accept && !dropping && start_blocked;

  // A refused frame is swallowed up to and including its in_last.
  always_ff @(posedge clk) begin
    if (reset)       dropping <= 1'b0;
    else if (accept) dropping <= dropping ? !in_last : (start_blocked && !in_last);
  end
`endif

  assign at_end   = (wr_cnt == LastIdx);
  assign commit   = take && in_last && at_end;
  assign misalign = take && (in_last != at_end);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt    <= '0;
      wr_bank   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (take) begin
        wr_cnt <= (in_last || at_end) ? '0 : wr_cnt + NBits'(1);
        if (commit) wr_bank <= ~wr_bank;
      end
      if (misalign || overflow) frame_err <= 1'b1;
    end
  end

  // ------------------------------------------------------- magnitude pipeline
  assign re_x = (2*DW)'(re);
  assign im_x = (2*DW)'(im);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= take;
      s2_valid <= s1_valid;
    end
  end

  // NOTE: datapath registers and the frame RAM have no reset; the valid flags qualify them.
  always_ff @(posedge clk) begin
    if (take) begin
      s1_rr     <= re_x * re_x;
      s1_ii     <= im_x * im_x;
      s1_addr   <= wr_cnt;
      s1_bank   <= wr_bank;
      s1_commit <= commit;
    end
    if (s1_valid) begin
      s2_sum    <= W'(s1_rr) + W'(s1_ii);
      s2_addr   <= s1_addr;
      s2_bank   <= s1_bank;
      s2_commit <= s1_commit;
    end
    if (s2_valid) mem[{s2_bank, s2_addr}] <= s2_sum;
  end

  // ---------------------------------------------------------- bank bookkeeping
  assign full_set   = s2_valid && s2_commit;
  assign burst_done = (state == S_BURST) && (rd_cnt == LastIdx);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    full_nxt = full;
    if (burst_done) full_nxt[rd_bank] = 1'b0;
    if (full_set)   full_nxt[s2_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full    <= '0;
      rd_bank <= 1'b0;
    end else begin
      full <= full_nxt;
      if (burst_done) rd_bank <= ~rd_bank;
    end
  end

  // ----------------------------------------------------------------- read FSM
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (full[rd_bank]) state_nxt = S_PRIME;
      S_PRIME: state_nxt = S_BURST;
      S_BURST: if (rd_cnt == LastIdx) state_nxt = S_GAP;
      S_GAP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mag_valid = (state == S_BURST);
    rd_en     = (state == S_PRIME) || (state == S_BURST && rd_cnt != LastIdx);
    rd_addr   = (state == S_BURST) ? rd_cnt + NBits'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset)                  rd_cnt <= '0;
    else if (state == S_PRIME)  rd_cnt <= '0;
    else if (state == S_BURST)  rd_cnt <= rd_cnt + NBits'(1);
  end

  // The read register only loads in PRIME/BURST, so mag holds between bursts.
  always_ff @(posedge clk) begin
    if (reset)      mag <= '0;
    else if (rd_en) mag <= mem[{rd_bank, rd_addr}];
  end

endmodule

// File: tb/tb_fft_mag_stream.sv
// Self-checking bench for fft_mag_stream: drives frames and compares each replayed burst
// against a frame-level model of the expected magnitude stream.
module tb_fft_mag_stream;
  localparam int NS = 256;
  localparam int DW = 16;
  localparam int W  = 2*DW+1;

  logic                 clk      = 1'b0;
  logic                 reset    = 1'b1;
  logic signed [DW-1:0] re       = '0;
  logic signed [DW-1:0] im       = '0;
  logic                 in_valid = 1'b0;
  logic                 in_last  = 1'b0;
  logic                 in_ready;
  logic [W-1:0]         mag;
  logic                 mag_valid;
  logic                 frame_err;

  int errors        = 0;
  int checks        = 0;
  int cyc           = 0;
  int last_acc_edge = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_mag_stream #(.NSamples(NS), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .re        (re),
    .im        (im),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .mag       (mag),
    .mag_valid (mag_valid),
    .frame_err (frame_err)
  );

  // Output monitor: records every contiguous mag_valid run.
  logic [W-1:0] got_data[$];
  int           got_len[$];
  int           got_start[$];
  int           cur_len   = 0;
  int           cur_start = 0;

  always @(negedge clk) begin
    if (mag_valid) begin
      if (cur_len == 0) cur_start <= cyc;
      got_data.push_back(mag);
      cur_len <= cur_len + 1;
    end else if (cur_len != 0) begin
      got_len.push_back(cur_len);
      got_start.push_back(cur_start);
      cur_len <= 0;
    end
  end

  // Reference model: frames of |X|^2 in arrival order; only complete, aligned frames replay.
  logic [W-1:0] exp_data[$];
  logic [W-1:0] cur_frame[$];
  bit           exp_err = 1'b0;

  task automatic model_beat(input int r, input int i, input bit last);
    logic [W-1:0] m;
    m = W'(longint'(r) * longint'(r) + longint'(i) * longint'(i));
    cur_frame.push_back(m);
    if (last || cur_frame.size() == NS) begin
      if (last && cur_frame.size() == NS) begin
        foreach (cur_frame[j]) exp_data.push_back(cur_frame[j]);
      end else begin
        exp_err = 1'b1;
      end
      cur_frame.delete();
    end
  endtask

  task automatic beat(input bit v, input int r, input int i, input bit last);
    in_valid = v;
    re       = DW'(r);
    im       = DW'(i);
    in_last  = last;
    if (v && in_ready) begin
      model_beat(r, i, last);
      if (last) last_acc_edge = cyc + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic flush_capture();
    got_data.delete();
    got_len.delete();
    got_start.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    re = '0;
    im = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    cur_frame.delete();
    exp_data.delete();
    exp_err = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    flush_capture();
  endtask

  task automatic wait_bursts(input int n, input int budget, input string name);
    int k = 0;
    while (got_len.size() < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    checks++;
    if (got_len.size() < n) begin
      errors++;
      $display("FAIL %s_timeout: bursts seen %0d, required %0d", name, got_len.size(), n);
    end
  endtask

  function automatic int srand16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    do_reset();
    checks++;
    if (mag !== '0) begin errors++; $display("FAIL reset_mag: got %0d, want 0", mag); end
    checks++;
    if (mag_valid !== 1'b0) begin errors++; $display("FAIL reset_mag_valid: got %b, want 0", mag_valid); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b, want 0", frame_err); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, want 1", in_ready); end
  endtask

  task automatic test_single_frame();
    do_reset();
    for (int n = 0; n < NS; n++) beat(1'b1, 3, 4, n == NS-1);
    idle();
    wait_bursts(1, 1000, "single");
    if (got_len.size() >= 1) begin
      checks++;
      if (got_len[0] !== NS) begin errors++; $display("FAIL single_len: got %0d, want %0d", got_len[0], NS); end
      checks++;
      if (got_start[0] - last_acc_edge !== 4) begin
        errors++;
        $display("FAIL single_latency: got %0d, want 4", got_start[0] - last_acc_edge);
      end
    end
    for (int j = 0; j < NS && j < got_data.size(); j++) begin
      checks++;
      if (got_data[j] !== 33'd25) begin errors++; $display("FAIL single_mag[%0d]: got %0d, want 25", j, got_data[j]); end
    end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL single_frame_err: got %b, want 0", frame_err); end
  endtask

  task automatic test_extremes();
    do_reset();
    for (int n = 0; n < NS; n++) begin
      if (n == 0)      beat(1'b1, -32768, -32768, 1'b0);
      else if (n == 1) beat(1'b1, 32767, 0, 1'b0);
      else             beat(1'b1, 0, 0, n == NS-1);
    end
    idle();
    wait_bursts(1, 1000, "extremes");
    if (got_data.size() >= NS) begin
      checks++;
      if (got_data[0] !== 33'd2147483648) begin errors++; $display("FAIL extremes_mag0: got %0d, want 2147483648", got_data[0]); end
      checks++;
      if (got_data[1] !== 33'd1073676289) begin errors++; $display("FAIL extremes_mag1: got %0d, want 1073676289", got_data[1]); end
      for (int j = 2; j < NS; j++) begin
        checks++;
        if (got_data[j] !== exp_data[j]) begin errors++; $display("FAIL extremes_mag[%0d]: got %0d, want %0d", j, got_data[j], exp_data[j]); end
      end
    end
  endtask

  task automatic test_gappy();
    do_reset();
    for (int n = 0; n < NS; n++) begin
      beat(1'b1, n, 0, n == NS-1);
      beat(1'b0, srand16(), srand16(), 1'($urandom_range(0, 1)));
    end
    idle();
    wait_bursts(1, 1000, "gappy");
    if (got_len.size() >= 1) begin
      checks++;
      if (got_len[0] !== NS) begin errors++; $display("FAIL gappy_len: got %0d, want %0d", got_len[0], NS); end
    end
    checks++;
    if (got_data.size() !== exp_data.size()) begin errors++; $display("FAIL gappy_count: got %0d, want %0d", got_data.size(), exp_data.size()); end
    for (int j = 0; j < exp_data.size() && j < got_data.size(); j++) begin
      checks++;
      if (got_data[j] !== exp_data[j]) begin errors++; $display("FAIL gappy_mag[%0d]: got %0d, want %0d", j, got_data[j], exp_data[j]); end
    end
  endtask

  task automatic test_early_last();
    do_reset();
    for (int n = 0; n < 100; n++) beat(1'b1, 5, 5, n == 99);
    idle();
    repeat (300) @(negedge clk);
    #1;
    checks++;
    if (got_len.size() !== 0) begin errors++; $display("FAIL early_no_burst: got %0d bursts, want 0", got_len.size()); end
    checks++;
    if (frame_err !== 1'b1) begin errors++; $display("FAIL early_frame_err: got %b, want 1", frame_err); end
    for (int n = 0; n < NS; n++) beat(1'b1, srand16(), srand16(), n == NS-1);
    idle();
    wait_bursts(1, 1000, "early_next");
    if (got_len.size() >= 1) begin
      checks++;
      if (got_len[0] !== NS) begin errors++; $display("FAIL early_next_len: got %0d, want %0d", got_len[0], NS); end
    end
    for (int j = 0; j < exp_data.size() && j < got_data.size(); j++) begin
      checks++;
      if (got_data[j] !== exp_data[j]) begin errors++; $display("FAIL early_next_mag[%0d]: got %0d, want %0d", j, got_data[j], exp_data[j]); end
    end
    checks++;
    if (frame_err !== exp_err) begin errors++; $display("FAIL early_sticky: got %b, want %b", frame_err, exp_err); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int f = 1; f <= 3; f++)
      for (int n = 0; n < NS; n++) beat(1'b1, f, 0, n == NS-1);
    idle();
    wait_bursts(3, 2000, "b2b");
    for (int k = 0; k < got_len.size(); k++) begin
      checks++;
      if (got_len[k] !== NS) begin errors++; $display("FAIL b2b_len[%0d]: got %0d, want %0d", k, got_len[k], NS); end
      if (k > 0) begin
        checks++;
        if (got_start[k] < got_start[k-1] + got_len[k-1] + 1) begin
          errors++;
          $display("FAIL b2b_gap[%0d]: start %0d, previous ends %0d", k, got_start[k], got_start[k-1] + got_len[k-1] - 1);
        end
      end
    end
    checks++;
    if (got_data.size() !== 3*NS) begin errors++; $display("FAIL b2b_count: got %0d, want %0d", got_data.size(), 3*NS); end
    for (int j = 0; j < 3*NS && j < got_data.size(); j++) begin
      checks++;
      if (got_data[j] !== W'((j/NS + 1) * (j/NS + 1))) begin
        errors++;
        $display("FAIL b2b_mag[%0d]: got %0d, want %0d", j, got_data[j], (j/NS + 1) * (j/NS + 1));
      end
    end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL b2b_frame_err: got %b, want 0", frame_err); end
  endtask

  task automatic test_random_gaps();
    do_reset();
    for (int f = 0; f < 2; f++) begin
      int n = 0;
      while (n < NS) begin
        if ($urandom_range(0, 9) < 7) begin
          beat(1'b1, srand16(), srand16(), n == NS-1);
          n++;
        end else begin
          beat(1'b0, srand16(), srand16(), 1'($urandom_range(0, 1)));
        end
      end
    end
    idle();
    wait_bursts(2, 2000, "random");
    checks++;
    if (got_data.size() !== exp_data.size()) begin errors++; $display("FAIL random_count: got %0d, want %0d", got_data.size(), exp_data.size()); end
    for (int j = 0; j < exp_data.size() && j < got_data.size(); j++) begin
      checks++;
      if (got_data[j] !== exp_data[j]) begin errors++; $display("FAIL random_mag[%0d]: got %0d, want %0d", j, got_data[j], exp_data[j]); end
    end
    checks++;
    if (frame_err !== exp_err) begin errors++; $display("FAIL random_frame_err: got %b, want %b", frame_err, exp_err); end
  endtask

  task automatic test_reset_mid_burst();
    int k = 0;
    do_reset();
    for (int n = 0; n < NS; n++) beat(1'b1, int'($urandom_range(0, 1000)), 7, n == NS-1);
    idle();
    while (cur_len < 50 && k < 1000) begin
      @(negedge clk);
      #1;
      k++;
    end
    checks++;
    if (cur_len < 50) begin errors++; $display("FAIL midrst_timeout: burst beats %0d, required 50", cur_len); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (mag_valid !== 1'b0) begin errors++; $display("FAIL midrst_mag_valid: got %b, want 0", mag_valid); end
    checks++;
    if (mag !== '0) begin errors++; $display("FAIL midrst_mag: got %0d, want 0", mag); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL midrst_frame_err: got %b, want 0", frame_err); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b, want 1", in_ready); end
    reset = 1'b0;
    cur_frame.delete();
    exp_data.delete();
    exp_err = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    flush_capture();
    for (int n = 0; n < NS; n++) beat(1'b1, srand16(), srand16(), n == NS-1);
    idle();
    wait_bursts(1, 1000, "midrst_next");
    if (got_len.size() >= 1) begin
      checks++;
      if (got_len[0] !== NS) begin errors++; $display("FAIL midrst_next_len: got %0d, want %0d", got_len[0], NS); end
    end
    for (int j = 0; j < exp_data.size() && j < got_data.size(); j++) begin
      checks++;
      if (got_data[j] !== exp_data[j]) begin errors++; $display("FAIL midrst_next_mag[%0d]: got %0d, want %0d", j, got_data[j], exp_data[j]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_extremes();
    test_gappy();
    test_early_last();
    test_back_to_back();
    test_random_gaps();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
